// File: rtl/icb_pkg.sv
// ---------------------------------------------------------------------------
// icb_pkg
// Shared ICB bus definitions used by the conv engine's SRAM responders:
// bus widths, the per-region window base addresses and the response entry
// layout {err, rdata} that is carried through the response FIFO.
// ---------------------------------------------------------------------------
package icb_pkg;

  localparam int ICB_AW = 32;  // byte address width
  localparam int ICB_DW = 32;  // data width
  localparam int ICB_MW = 4;   // byte-enable width

  localparam logic [31:0] WGT_BASE = 32'h0000_2000;
  localparam logic [31:0] INP_BASE = 32'h4000_0000;
  localparam logic [31:0] OUT_BASE = 32'h6000_0000;

  typedef struct packed {
    logic              err;
    logic [ICB_DW-1:0] rdata;
  } icb_rsp_t;

  localparam int RSP_W = $bits(icb_rsp_t);

endpackage

// File: rtl/icb_rsp_fifo.sv
// ---------------------------------------------------------------------------
// icb_rsp_fifo
// Synchronous FIFO holding ICB responses. The head entry is read directly
// from the storage array at the read pointer (registered state only), so the
// output never depends combinationally on the push side.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset (pointers/count only)
//   i_push   in   write i_wdata at the tail
//   i_wdata  in   W-bit entry
//   i_pop    in   drop the head entry
//   o_rdata  out  head entry (meaningful while o_empty=0)
//   o_cnt    out  number of stored entries, log2(DEPTH)+1 bits
//   o_full   out  o_cnt == DEPTH
//   o_empty  out  o_cnt == 0
// ---------------------------------------------------------------------------
module icb_rsp_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_pop,
  output logic [W-1:0]             o_rdata,
  output logic [$clog2(DEPTH):0]   o_cnt,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [0:DEPTH-1];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_cnt;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PW'(1);
      if (i_pop)  r_rptr <= r_rptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage is not reset; validity is tracked by r_cnt alone.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_cnt   = r_cnt;
  assign o_full  = (r_cnt == (PW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/conv_icb_sram_slave.sv
// ---------------------------------------------------------------------------
// conv_icb_sram_slave
// ICB responder serving one SRAM window (WGT/INP/OUT region) for the conv
// engine master port. Commands are decoded and executed on the accept edge;
// the result goes through a one-entry stage (_p1) and then into a response
// FIFO whose head register drives the response channel. cmd_ready is derived
// only from registered occupancy, so there is no comb path rsp_ready->cmd.
//
// Ports
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-high reset
//   icb_cmd_valid  in   command valid
//   icb_cmd_ready  out  command ready
//   icb_cmd_addr   in   32-bit byte address
//   icb_cmd_read   in   1=read, 0=write
//   icb_cmd_wdata  in   write data
//   icb_cmd_wmask  in   byte enables, bit i -> wdata[8i+7:8i]
//   icb_rsp_valid  out  response valid
//   icb_rsp_ready  in   response ready
//   icb_rsp_rdata  out  read data (0 for writes and errors)
//   icb_rsp_err    out  out-of-window or misaligned access
//   err_cnt        out  saturating count of error responses
// ---------------------------------------------------------------------------
module conv_icb_sram_slave
  import icb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
  parameter int          AW         = 12,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        icb_cmd_valid,
  output logic        icb_cmd_ready,
  input  logic [31:0] icb_cmd_addr,
  input  logic        icb_cmd_read,
  input  logic [31:0] icb_cmd_wdata,
  input  logic [3:0]  icb_cmd_wmask,
  output logic        icb_rsp_valid,
  input  logic        icb_rsp_ready,
  output logic [31:0] icb_rsp_rdata,
  output logic        icb_rsp_err,
  output logic [15:0] err_cnt
);

  localparam int          CW        = $clog2(FIFO_DEPTH);
  localparam logic [32:0] WIN_BYTES = 33'(4) << AW;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [31:0]   w_off;
  logic          w_hit;
  logic          w_acc;
  logic          w_wr;
  logic [AW-1:0] w_idx;

  logic [31:0]   r_mem [0:(1<<AW)-1];

  logic          r_vld_p1;
  logic          r_err_p1;
  logic [31:0]   r_data_p1;
  logic [15:0]   r_err_cnt;

  icb_rsp_t      w_push_ent;
  icb_rsp_t      w_head;
  logic [CW:0]   w_fifo_cnt;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic          w_pop;
  logic [CW+1:0] w_occ;

  // Unsigned wrap of (addr - base) makes addresses below the base fall out
  // of the window as well.
  assign w_off = icb_cmd_addr - BASE_ADDR;
  assign w_hit = ({1'b0, w_off} < WIN_BYTES) && (icb_cmd_addr[1:0] == 2'b00);
  assign w_idx = w_off[AW+1:2];

  // Occupancy counts the stage-1 entry that is about to land in the FIFO.
  // full already implies occ >= FIFO_DEPTH; it is kept as an explicit guard.
  assign w_occ         = {1'b0, w_fifo_cnt} + {{(CW+1){1'b0}}, r_vld_p1};
  assign icb_cmd_ready = !rst && !w_fifo_full && (w_occ < (CW+2)'(FIFO_DEPTH));
  assign w_acc         = icb_cmd_valid && icb_cmd_ready;
  assign w_wr          = w_acc && w_hit && !icb_cmd_read;

  // ---- stage p0 -> p1: SRAM access on the accept edge ----
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int b = 0; b < ICB_MW; b++) begin
        if (icb_cmd_wmask[b]) r_mem[w_idx][8*b +: 8] <= icb_cmd_wdata[8*b +: 8];
      end
    end
    if (w_acc) r_data_p1 <= (w_hit && icb_cmd_read) ? r_mem[w_idx] : 32'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_err_p1  <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_vld_p1 <= w_acc;
      if (w_acc) r_err_p1 <= !w_hit;
      // Errors are counted when the failing command is accepted.
      if (w_acc && !w_hit) r_err_cnt <= sat_inc16(r_err_cnt);
    end
  end

  // ---- stage p1 -> FIFO: response queue ----
  assign w_push_ent = {r_err_p1, r_data_p1};
  assign w_pop      = icb_rsp_valid && icb_rsp_ready;

  icb_rsp_fifo #(
    .W     (RSP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_vld_p1),
    .i_wdata (w_push_ent),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_cnt   (w_fifo_cnt),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Payload is forced to zero when nothing is presented so that the storage
  // array's stale contents never appear on the bus.
  assign icb_rsp_valid = !w_fifo_empty;
  assign icb_rsp_rdata = icb_rsp_valid ? w_head.rdata : 32'h0;
  assign icb_rsp_err   = icb_rsp_valid ? w_head.err   : 1'b0;
  assign err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_conv_icb_sram_slave.sv
module tb_conv_icb_sram_slave;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int          AW   = 12;
  localparam int          FD   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        icb_cmd_valid = 1'b0;
  logic        icb_cmd_ready;
  logic [31:0] icb_cmd_addr  = 32'h0;
  logic        icb_cmd_read  = 1'b0;
  logic [31:0] icb_cmd_wdata = 32'h0;
  logic [3:0]  icb_cmd_wmask = 4'h0;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready = 1'b0;
  logic [31:0] icb_rsp_rdata;
  logic        icb_rsp_err;
  logic [15:0] err_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // Responses observed on the bus, in order: {err, rdata}
  logic [32:0] got[$];

  always #5 clk = ~clk;

  conv_icb_sram_slave #(
    .BASE_ADDR  (BASE),
    .AW         (AW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .icb_cmd_valid (icb_cmd_valid),
    .icb_cmd_ready (icb_cmd_ready),
    .icb_cmd_addr  (icb_cmd_addr),
    .icb_cmd_read  (icb_cmd_read),
    .icb_cmd_wdata (icb_cmd_wdata),
    .icb_cmd_wmask (icb_cmd_wmask),
    .icb_rsp_valid (icb_rsp_valid),
    .icb_rsp_ready (icb_rsp_ready),
    .icb_rsp_rdata (icb_rsp_rdata),
    .icb_rsp_err   (icb_rsp_err),
    .err_cnt       (err_cnt)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One bus cycle: drive at the falling edge, sample 1 ns later, return at
  // the next falling edge. Records accepted responses into got[].
  task automatic cyc(input logic v, input logic rd, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] m, input logic rr,
                     output logic acc);
    icb_cmd_valid = v;
    icb_cmd_read  = rd;
    icb_cmd_addr  = a;
    icb_cmd_wdata = wd;
    icb_cmd_wmask = m;
    icb_rsp_ready = rr;
    #1;
    acc = v && icb_cmd_ready;
    if (icb_rsp_valid && rr) got.push_back({icb_rsp_err, icb_rsp_rdata});
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rr);
    logic acc;
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rr, acc);
  endtask

  // Hold a command until accepted, bounded to 40 cycles.
  task automatic send(input logic rd, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] m, input logic rr);
    logic acc;
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      cyc(1'b1, rd, a, wd, m, rr, acc);
      ok = acc;
    end
    icb_cmd_valid = 1'b0;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_timeout addr=%h not accepted within 40 cycles", a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_chk++; if (icb_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready got %b want 0", icb_cmd_ready); end
    n_chk++; if (icb_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", icb_rsp_valid); end
    n_chk++; if (icb_rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata got %h want 0", icb_rsp_rdata); end
    n_chk++; if (icb_rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %b want 0", icb_rsp_err); end
    n_chk++; if (err_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_err_cnt got %h want 0", err_cnt); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++; if (icb_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %b want 1", icb_cmd_ready); end
    @(negedge clk);
  endtask

  task automatic test_write_read();
    logic acc;
    got.delete();
    send(1'b0, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1);
    idle(3, 1'b1);
    n_chk++; if (got.size() != 1 || got[0] !== 33'h0) begin n_fail++; $display("FAIL wr_rsp got n=%0d e0=%h want n=1 e0=0", got.size(), got[0]); end
    got.delete();
    send(1'b1, BASE + 32'h10, 32'h0, 4'h0, 1'b0);
    n_chk++; if (icb_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_latency_n1 rsp_valid got %b want 0", icb_rsp_valid); end
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, acc);
    #1;
    n_chk++; if (icb_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rd_latency_n2 rsp_valid got %b want 1", icb_rsp_valid); end
    n_chk++; if (icb_rsp_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_data got %h want deadbeef", icb_rsp_rdata); end
    n_chk++; if (icb_rsp_err !== 1'b0) begin n_fail++; $display("FAIL rd_err got %b want 0", icb_rsp_err); end
    @(negedge clk);
    // Response must stay stable while stalled
    n_chk++; if (icb_rsp_valid !== 1'b1 || icb_rsp_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_stall_hold got v=%b d=%h want v=1 d=deadbeef", icb_rsp_valid, icb_rsp_rdata); end
    idle(2, 1'b1);
    n_chk++; if (icb_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_pop rsp_valid got %b want 0", icb_rsp_valid); end
  endtask

  task automatic test_byte_mask();
    got.delete();
    send(1'b0, BASE + 32'h20, 32'h1122_3344, 4'hF,    1'b1);
    send(1'b0, BASE + 32'h20, 32'hAABB_CCDD, 4'b0101, 1'b1);
    send(1'b1, BASE + 32'h20, 32'h0,         4'h0,    1'b1);
    send(1'b0, BASE + 32'h20, 32'hFFFF_FFFF, 4'b0000, 1'b1);
    send(1'b1, BASE + 32'h20, 32'h0,         4'h0,    1'b1);
    idle(5, 1'b1);
    n_chk++; if (got.size() != 5) begin n_fail++; $display("FAIL mask_count got %0d want 5", got.size()); end
    n_chk++; if (got[2] !== {1'b0, 32'h11BB_33DD}) begin n_fail++; $display("FAIL mask_merge got %h want 0_11bb33dd", got[2]); end
    n_chk++; if (got[3] !== 33'h0) begin n_fail++; $display("FAIL mask_zero_rsp got %h want 0", got[3]); end
    n_chk++; if (got[4] !== {1'b0, 32'h11BB_33DD}) begin n_fail++; $display("FAIL mask_zero_nochange got %h want 0_11bb33dd", got[4]); end
  endtask

  task automatic test_errors();
    logic [32:0] exp[$];
    got.delete();
    send(1'b1, BASE + 32'h4000, 32'h0, 4'h0, 1'b1);
    send(1'b1, BASE + 32'h2,    32'h0, 4'h0, 1'b1);
    idle(4, 1'b1);
    n_chk++; if (got.size() != 2 || got[0] !== {1'b1, 32'h0} || got[1] !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL err_rsp got n=%0d %h %h want n=2 1_00000000 x2", got.size(), got[0], got[1]); end
    n_chk++; if (err_cnt !== 16'd2) begin n_fail++; $display("FAIL err_cnt2 got %0d want 2", err_cnt); end
    got.delete();
    exp = '{ {1'b1, 32'h0}, {1'b1, 32'h0}, 33'h0, {1'b0, 32'hCAFE_F00D}, {1'b0, 32'hDEAD_BEEF} };
    send(1'b0, BASE + 32'h12,     32'h0,         4'hF, 1'b1);
    send(1'b0, BASE - 32'h4,      32'h0,         4'hF, 1'b1);
    send(1'b0, BASE + 32'h3FFC,   32'hCAFE_F00D, 4'hF, 1'b1);
    send(1'b1, BASE + 32'h3FFC,   32'h0,         4'h0, 1'b1);
    send(1'b1, BASE + 32'h10,     32'h0,         4'h0, 1'b1);
    idle(5, 1'b1);
    n_chk++; if (got.size() != exp.size()) begin n_fail++; $display("FAIL err_seq_count got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      n_chk++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL err_seq[%0d] got %h want %h", i, got[i], exp[i]); end
    end
    n_chk++; if (err_cnt !== 16'd4) begin n_fail++; $display("FAIL err_cnt4 got %0d want 4", err_cnt); end
  endtask

  task automatic test_back_to_back();
    logic        acc;
    logic [32:0] exp[$];
    int          n_acc;
    for (int i = 0; i < 8; i++) send(1'b0, BASE + 32'h100 + 32'(4*i), 32'hB000_0000 + 32'(i), 4'hF, 1'b1);
    idle(4, 1'b1);
    got.delete();
    for (int i = 0; i < 36; i++) begin
      cyc(1'b1, 1'b1, BASE + 32'h100 + 32'(4*(i%8)), 32'h0, 4'h0, 1'b1, acc);
      exp.push_back({1'b0, 32'hB000_0000 + 32'(i%8)});
      n_chk++; if (acc !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got %b want 1", i, acc); end
    end
    icb_cmd_valid = 1'b0;
    idle(5, 1'b1);
    n_chk++; if (got.size() != 36) begin n_fail++; $display("FAIL b2b_count got %0d want 36", got.size()); end
    for (int i = 0; i < 36; i++) begin
      n_chk++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL b2b_data[%0d] got %h want %h", i, got[i], exp[i]); end
    end
    // Stall the response side: only FIFO_DEPTH commands may be taken
    got.delete();
    exp.delete();
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, BASE + 32'h100 + 32'(4*(i%8)), 32'h0, 4'h0, 1'b0, acc);
      if (acc) begin
        n_acc++;
        exp.push_back({1'b0, 32'hB000_0000 + 32'(i%8)});
      end
    end
    #1;
    n_chk++; if (n_acc != FD) begin n_fail++; $display("FAIL stall_accepts got %0d want %0d", n_acc, FD); end
    n_chk++; if (icb_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready got %b want 0", icb_cmd_ready); end
    icb_cmd_valid = 1'b0;
    @(negedge clk);
    idle(8, 1'b1);
    n_chk++; if (got.size() != 4) begin n_fail++; $display("FAIL stall_count got %0d want 4", got.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      n_chk++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL stall_data[%0d] got %h want %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    got.delete();
    send(1'b1, BASE + 32'h100, 32'h0,         4'h0, 1'b0);
    send(1'b1, BASE + 32'h104, 32'h0,         4'h0, 1'b0);
    send(1'b0, BASE + 32'h40,  32'h5A5A_1234, 4'hF, 1'b0);
    rst = 1'b1;
    #1;
    n_chk++; if (icb_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rsp_valid got %b want 0", icb_rsp_valid); end
    n_chk++; if (icb_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready got %b want 0", icb_cmd_ready); end
    @(negedge clk);
    #1;
    n_chk++; if (err_cnt !== 16'h0) begin n_fail++; $display("FAIL rstmid_err_cnt got %0d want 0", err_cnt); end
    n_chk++; if (icb_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rsp_valid_n1 got %b want 0", icb_rsp_valid); end
    rst = 1'b0;
    @(negedge clk);
    send(1'b1, BASE + 32'h40, 32'h0, 4'h0, 1'b1);
    idle(5, 1'b1);
    n_chk++; if (got.size() != 1) begin n_fail++; $display("FAIL rstmid_count got %0d want 1", got.size()); end
    n_chk++; if (got[0] !== {1'b0, 32'h5A5A_1234}) begin n_fail++; $display("FAIL rstmid_keep got %h want 0_5a5a1234", got[0]); end
  endtask

  task automatic test_random();
    logic [31:0] mdl[16];
    logic [32:0] exp[$];
    logic        acc, v, rd, miss, rr;
    logic [3:0]  k, m;
    logic [31:0] a, wd;
    int          n_err_exp;
    for (int i = 0; i < 16; i++) begin
      mdl[i] = $urandom;
      send(1'b0, BASE + 32'h200 + 32'(4*i), mdl[i], 4'hF, 1'b1);
    end
    idle(5, 1'b1);
    got.delete();
    n_err_exp = 0;
    for (int n = 0; n < 2000; n++) begin
      v    = ($urandom_range(0, 9) < 7);
      rd   = 1'($urandom_range(0, 1));
      k    = 4'($urandom_range(0, 15));
      miss = ($urandom_range(0, 7) == 0);
      wd   = $urandom;
      m    = 4'($urandom_range(0, 15));
      rr   = ($urandom_range(0, 9) < 7);
      if (!miss)     a = BASE + 32'h200  + 32'(4*k);
      else if (k[0]) a = BASE + 32'h4000 + 32'(4*k);
      else           a = BASE + 32'h201  + 32'(4*k);
      cyc(v, rd, a, wd, m, rr, acc);
      if (acc) begin
        if (miss) begin
          exp.push_back({1'b1, 32'h0});
          n_err_exp++;
        end else if (rd) begin
          exp.push_back({1'b0, mdl[k]});
        end else begin
          for (int b = 0; b < 4; b++) if (m[b]) mdl[k][8*b +: 8] = wd[8*b +: 8];
          exp.push_back(33'h0);
        end
      end
      n_chk++; if (dut.w_fifo_cnt > 3'(FD)) begin n_fail++; $display("FAIL rnd_fifo_overflow cnt %0d max %0d", dut.w_fifo_cnt, FD); end
    end
    icb_cmd_valid = 1'b0;
    idle(20, 1'b1);
    n_chk++; if (got.size() != exp.size()) begin n_fail++; $display("FAIL rnd_count got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_chk++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL rnd_data[%0d] got %h want %h", i, got[i], exp[i]); end
    end
    n_chk++; if (err_cnt !== 16'(n_err_exp)) begin n_fail++; $display("FAIL rnd_err_cnt got %0d want %0d", err_cnt, n_err_exp); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_mask();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
